// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the default operand width.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// subtract the divisor when it fits and report the resulting quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The extra top bit keeps the compare exact; the difference itself is
    // always below the divisor, so a WIDTH-bit subtract is enough.
    assign shifted = {rem, bit_in};
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, fixed WIDTH+1 latency.
// Define DIV_SIGNED_EN to add the signedOp port and two's-complement division.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
`ifdef DIV_SIGNED_EN
    input  logic             signedOp,
`endif
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;

`ifdef DIV_SIGNED_EN
    assign is_signed = signedOp;
`else
    assign is_signed = 1'b0;
`endif

    // Divide magnitudes; signs are reapplied in FINISH. The most-negative
    // value negates to itself, which is its correct unsigned magnitude.
    assign a_neg = is_signed & srcA[WIDTH-1];
    assign b_neg = is_signed & srcB[WIDTH-1];
    assign mag_a = a_neg ? -srcA : srcA;
    assign mag_b = b_neg ? -srcB : srcB;

    assign busy = (state == RUN);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .divisor (dvs),
        .bit_in  (quo[WIDTH-1]),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && srcB != '0) state_nxt = RUN;
            RUN:     if (count == CW'(WIDTH - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_nxt;
            done    <= 1'b0;
            divZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (srcB == '0) begin
                            done    <= 1'b1;
                            divZero <= 1'b1;
                        end else begin
                            // quo doubles as the dividend shift register
                            rem   <= '0;
                            quo   <= mag_a;
                            dvs   <= mag_b;
                            count <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_nxt;
                    quo   <= {quo[WIDTH-2:0], q_bit};
                    count <= count + 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    lo   <= neg_q ? -quo : quo;
                    hi   <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed scoreboard bench for div_seq (WIDTH=32); signed cases are built
// only when DIV_SIGNED_EN is defined.
module tb_div_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
`ifdef DIV_SIGNED_EN
    logic         signed_op = 1'b0;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .srcA     (src_a),
        .srcB     (src_b),
`ifdef DIV_SIGNED_EN
        .signedOp (signed_op),
`endif
        .busy     (busy),
        .done     (done),
        .divZero  (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] l, input logic [W-1:0] h, input logic dz);
        exp_t e;
        e.lo = l;
        e.hi = h;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Present operands before an edge and release start just after it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        @(negedge clk);
        src_a = a;
        src_b = b;
`ifdef DIV_SIGNED_EN
        signed_op = sgn;
`else
        if (sgn) $display("note: signed case skipped in unsigned build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; counts edges to done.
    task automatic wait_done(input string tag, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        reset = 1'b1;
        start = 1'b0;
        src_a = '0;
        src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(div_zero), 64'd0);
        chk("rst_hi",   64'(hi), 64'd0);
        chk("rst_lo",   64'(lo), 64'd0);
        reset = 1'b0;

        // basic division, latency 33
        push_exp(32'd14, 32'd2, 1'b0);
        issue(32'd100, 32'd7, 1'b0);
        chk("run_busy", 64'(busy), 64'd1);
        wait_done("d100_7", 33);
        @(posedge clk);
        #1 chk("done_pulse", 64'(done), 64'd0);
        chk("lo_hold", 64'(lo), 64'd14);

        // start held through RUN with operands changed after acceptance;
        // the held start is taken again in the done cycle
        push_exp(32'hFFFF_FFFF, 32'd0, 1'b0);
        push_exp(32'd0, 32'd5, 1'b0);
        @(negedge clk);
        src_a = 32'hFFFF_FFFF;
        src_b = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1 src_a = 32'd5;
        src_b = 32'd9;
        wait_done("dmax_1", 33);
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done("d5_9", 33);

        // zero divisor: immediate pulse, results untouched, never busy
        push_exp(32'd0, 32'd5, 1'b1);
        issue(32'd1234, 32'd0, 1'b0);
        chk("dz_busy", 64'(busy), 64'd0);
        chk("dz_done", 64'(done), 64'd1);
        wait_done("dz", 0);
        @(posedge clk);
        #1 chk("dz_pulse", 64'(div_zero), 64'd0);
        chk("dz_done_pulse", 64'(done), 64'd0);
        chk("dz_busy2", 64'(busy), 64'd0);

        // random unsigned operands against a bench-side reference
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 255)) : $urandom;
            if (b == '0) b = 32'd1;
            push_exp(a / b, a % b, 1'b0);
            issue(a, b, 1'b0);
            wait_done("rand", 33);
        end

        // reset during RUN discards the division
        issue(32'd200, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1 chk("mid_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dz",   64'(div_zero), 64'd0);
        chk("abort_hi",   64'(hi), 64'd0);
        chk("abort_lo",   64'(lo), 64'd0);
        reset = 1'b0;
        push_exp(32'd30, 32'd10, 1'b0);
        issue(32'd1000, 32'd33, 1'b0);
        wait_done("post_rst", 33);

`ifdef DIV_SIGNED_EN
        push_exp(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("s_m7_2", 33);
        push_exp(32'hFFFF_FFFD, 32'd1, 1'b0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("s_7_m2", 33);
        push_exp(32'h8000_0000, 32'd0, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("s_min_m1", 33);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
